multicycle_data_path: RTL and testbench
=======================================

MULTICYCLE_DATA_PATH -- requirements
Module: multicycle_data_path

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath/register/memory word width (legal values >= 32).
REQ-002 The block SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have control input ports RegSrc[1:0], RegWrite, ImmSrc[1:0], ALUSrc, ALUControl[1:0], MemtoReg, MemWrite, PCSrc, MOVInstr and link, all driven by the external decoder from Instr.
REQ-006 The block SHALL have port Instr, output, 32, the latched instruction register (IR).
REQ-007 The block SHALL have port PC, output, WIDTH, the program counter.
REQ-008 The block SHALL have port ALUFlags, output, 4, {N,Z,C,V} from the ALU in EXECUTE.
REQ-009 The block SHALL have ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, WIDTH), mem_wdata (output, WIDTH), mem_rdata (input, WIDTH) and mem_ready (input, 1), forming a unified memory port.
REQ-010 The block SHALL have port state, output, 3, the current FSM state.
REQ-011 The block SHALL have port instr_done, output, 1, a one-cycle retire pulse.
REQ-012 The block SHALL have ports instr_count and stall_count, output, 32 each, performance counters (see Configuration).

Function
REQ-013 The FSM SHALL have states FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3 and WRITEBACK=4.
REQ-014 In FETCH the block SHALL drive mem_req=1, mem_we=0 and mem_addr=PC; on mem_ready=1 it SHALL set IR<=mem_rdata[31:0] and PC<=PC+4, then go to DECODE; otherwise it SHALL stay in FETCH with its outputs stable.
REQ-015 In DECODE, register reads SHALL latch into A and B in one cycle, then the FSM SHALL go to EXECUTE.
- RA1 = RegSrc[0] ? 15 : Instr[19:16].
- RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
- A read of R15 SHALL return PC+4 (i.e. fetch address+8).
REQ-016 In EXECUTE the block SHALL latch ALUOut and ALUFlags, then go to MEMORY if (MemtoReg|MemWrite), else to WRITEBACK.
- SrcA = MOVInstr ? 0 : A.
- SrcB = ALUSrc ? ExtImm : shift(B).
REQ-017 The shifter SHALL use amount Instr[11:7] and type Instr[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); an amount of 0 SHALL pass B unchanged.
REQ-018 ExtImm SHALL be: ImmSrc 00 = zero-extended Instr[7:0]; 01 = zero-extended Instr[11:0]; 10 = sign-extended Instr[23:0]<<2 to WIDTH; 11 = 0.
REQ-019 ALUControl SHALL select 00 add, 01 sub (A-B), 10 AND, 11 OR, all modulo 2^WIDTH.
- C SHALL be the carry-out for add and NOT borrow for sub.
- V SHALL be the signed overflow for add/sub.
- C and V SHALL be 0 for AND/OR.
- N = MSB of the result; Z = (result==0).
REQ-020 In MEMORY the block SHALL drive mem_req=1, mem_addr=ALUOut, mem_we=MemWrite and mem_wdata=B, and wait for mem_ready.
- On ready with a load, it SHALL set Data<=mem_rdata and go to WRITEBACK.
- On ready with a store, it SHALL pulse instr_done and go to FETCH.
REQ-021 In WRITEBACK, with Result = MemtoReg ? Data : ALUOut, the block SHALL:
- if RegWrite and Rd=Instr[15:12]!=15, write R[Rd]<=Result;
- if link, write R14<=PC;
- if PCSrc, set PC<=Result;
- pulse instr_done and go to FETCH.
REQ-022 If link is set and Rd=14 with RegWrite in the same WRITEBACK, the link write SHALL win.
REQ-023 The register file SHALL hold R0..R14 only; R15 writes SHALL occur via PCSrc alone.
REQ-024 A load SHALL take 5 cycles and any other instruction 4 cycles, plus wait cycles with mem_ready=0; there is no timeout.
REQ-025 mem_req SHALL be 0 in DECODE, EXECUTE and WRITEBACK.
REQ-026 An undefined state encoding SHALL return to FETCH on the next clock.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for a clock edge, set state=FETCH, PC=RESET_PC, IR=0, A=B=ALUOut=Data=0, ALUFlags=0, instr_done=0, mem_req=0 (until reset deasserts), and counters=0.
REQ-028 The register contents R0..R14 SHALL be reset to 0.
REQ-029 Reset mid-transaction SHALL abandon the access, and no write SHALL complete.

Configuration
REQ-030 With macro MULTICYCLE_DP_PERF_CNT_EN defined, instr_count SHALL increment on every instr_done and stall_count on every cycle with mem_req=1 and mem_ready=0, both wrapping at 2^32.
REQ-031 Without MULTICYCLE_DP_PERF_CNT_EN, instr_count and stall_count SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-032 Reset, then release with mem_ready=1 -> the first mem_addr=RESET_PC, and the state sequence SHALL be 0,1,2,4,0.
REQ-033 ADD-imm R1=R0+5 (ALUSrc=1, ImmSrc=00), then SUB R2=R1-R1 -> R1=5, and the second EXECUTE gives ALUFlags=0110 (Z=1, C=1).
REQ-034 STR R1 to address 0x100 with mem_ready held low 3 cycles -> mem_we=1 and mem_addr=0x100 stable for 4 cycles; stall_count=3 (macro on); instr_done with no WRITEBACK.
REQ-035 Branch-with-link at PC=0x20, Instr[23:0]=2, PCSrc=1, link=1, operand R15 -> R14=0x24 and the next fetch address=0x30.
REQ-036 Assert reset in the MEMORY state of a store -> mem_req drops the same cycle and the target memory is unchanged.
REQ-037 0x7FFFFFFF add 1 -> result 0x80000000 and ALUFlags=1001 (N=1, V=1).

Source files
------------

// File: rtl/multicycle_data_path.sv
// Multicycle ARM-subset datapath: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK FSM
// with one unified memory port, a 15-entry register file (R15 reads return PC+4),
// a shifter, an immediate extender and a 4-op ALU with NZCV flags.
// Optional performance counters are enabled by defining MULTICYCLE_DP_PERF_CNT_EN.
module multicycle_data_path #(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [1:0]       RegSrc,
  input  logic             RegWrite,
  input  logic [1:0]       ImmSrc,
  input  logic             ALUSrc,
  input  logic [1:0]       ALUControl,
  input  logic             MemtoReg,
  input  logic             MemWrite,
  input  logic             PCSrc,
  input  logic             MOVInstr,
  input  logic             link,
  output logic [31:0]      Instr,
  output logic [WIDTH-1:0] PC,
  output logic [3:0]       ALUFlags,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [31:0]      instr_count,
  output logic [31:0]      stall_count
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4
  } state_t;

  state_t           cur, nxt;
  logic             done_next;
  logic [WIDTH-1:0] a_q, b_q, alu_out_q, data_q;
  logic [WIDTH-1:0] rf [0:14];

  logic [3:0]         ra1, ra2;
  logic [WIDTH-1:0]   pc_plus4, rd1, rd2;
  logic [4:0]         sh_amt;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   shifted, ext_imm, src_a, src_b, b_op, alu_res, result;
  logic [WIDTH:0]     sum;
  logic               sub, alu_c, alu_v;

  assign state = cur;

  // Register-file read ports; R15 is the architectural PC+8, i.e. current PC+4
  always_comb begin
    ra1      = RegSrc[0] ? 4'd15 : Instr[19:16];
    ra2      = RegSrc[1] ? Instr[15:12] : Instr[3:0];
    pc_plus4 = PC + WIDTH'(4);
    rd1      = (ra1 == 4'd15) ? pc_plus4 : rf[ra1];
    rd2      = (ra2 == 4'd15) ? pc_plus4 : rf[ra2];
  end

  // Barrel shifter on B and immediate extension
  always_comb begin
    sh_amt = Instr[11:7];
    rot    = {b_q, b_q} >> sh_amt;
    case (Instr[6:5])
      2'b00:   shifted = b_q << sh_amt;
      2'b01:   shifted = b_q >> sh_amt;
      2'b10:   shifted = WIDTH'($signed(b_q) >>> sh_amt);
      default: shifted = rot[WIDTH-1:0];
    endcase
    case (ImmSrc)
      2'b00:   ext_imm = WIDTH'(Instr[7:0]);
      2'b01:   ext_imm = WIDTH'(Instr[11:0]);
      2'b10:   ext_imm = {{(WIDTH-26){Instr[23]}}, Instr[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

  // ALU: add/sub share one adder (sub = A + ~B + 1, carry = NOT borrow)
  always_comb begin
    src_a = MOVInstr ? '0 : a_q;
    src_b = ALUSrc ? ext_imm : shifted;
    sub   = (ALUControl == 2'b01);
    b_op  = sub ? ~src_b : src_b;
    sum   = {1'b0, src_a} + {1'b0, b_op} + (WIDTH+1)'(sub);
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (ALUControl)
      2'b10:   alu_res = src_a & src_b;
      2'b11:   alu_res = src_a | src_b;
      default: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (src_a[WIDTH-1] == b_op[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
      end
    endcase
    result = MemtoReg ? data_q : alu_out_q;
  end

  // FSM state register
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // Next-state logic and memory-port drive; requests are gated off while in reset
  always_comb begin
    nxt       = cur;
    done_next = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = PC;
    mem_wdata = b_q;
    case (cur)
      S_FETCH: begin
        mem_req = reset;
        if (mem_ready) nxt = S_DECODE;
      end
      S_DECODE:  nxt = S_EXECUTE;
      S_EXECUTE: nxt = (MemtoReg || MemWrite) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        mem_req  = reset;
        mem_we   = reset && MemWrite;
        mem_addr = alu_out_q;
        if (mem_ready) begin
          if (MemWrite) begin
            nxt       = S_FETCH;
            done_next = 1'b1;
          end else begin
            nxt = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        nxt       = S_FETCH;
        done_next = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Datapath registers and register file; link write follows Rd write so it wins on R14
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      Instr      <= '0;
      PC         <= RESET_PC;
      a_q        <= '0;
      b_q        <= '0;
      alu_out_q  <= '0;
      data_q     <= '0;
      ALUFlags   <= '0;
      instr_done <= 1'b0;
      for (int i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      instr_done <= done_next;
      case (cur)
        S_FETCH: if (mem_ready) begin
          Instr <= mem_rdata[31:0];
          PC    <= pc_plus4;
        end
        S_DECODE: begin
          a_q <= rd1;
          b_q <= rd2;
        end
        S_EXECUTE: begin
          alu_out_q <= alu_res;
          ALUFlags  <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
        end
        S_MEMORY: if (mem_ready && !MemWrite) data_q <= mem_rdata;
        S_WRITEBACK: begin
          if (RegWrite && (Instr[15:12] != 4'd15)) rf[Instr[15:12]] <= result;
          if (link) rf[14] <= PC;
          if (PCSrc) PC <= result;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_DP_PERF_CNT_EN
  // Retired-instruction and memory-stall counters, wrapping at 2^32
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      instr_count <= instr_count + 32'(done_next);
      stall_count <= stall_count + 32'(mem_req && !mem_ready);
    end
  end
`else
  assign instr_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench for multicycle_data_path with a word memory model and a
// scoreboard queue of expected memory transactions per instruction.
module tb_multicycle_data_path;

  logic        CLK, reset;
  logic [1:0]  RegSrc, ImmSrc, ALUControl;
  logic        RegWrite, ALUSrc, MemtoReg, MemWrite, PCSrc, MOVInstr, link;
  logic [31:0] Instr, PC, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  ALUFlags;
  logic        mem_req, mem_we, mem_ready, instr_done;
  logic [2:0]  state;
  logic [31:0] instr_count, stall_count;

  logic [31:0] mem [0:255];
  int checks = 0;
  int errors = 0;
  bit done_exp = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;
  txn_t exp_mem[$];

  multicycle_data_path #(.WIDTH(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .reset(reset),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
    .ALUControl(ALUControl), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .PCSrc(PCSrc), .MOVInstr(MOVInstr), .link(link),
    .Instr(Instr), .PC(PC), .ALUFlags(ALUFlags),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .state(state), .instr_done(instr_done),
    .instr_count(instr_count), .stall_count(stall_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge CLK) begin
    if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input logic [1:0] rs, input logic rw, input logic [1:0] is,
                     input logic as, input logic [1:0] ac, input logic m2r,
                     input logic mw, input logic pcs, input logic mov, input logic lk);
    RegSrc = rs; RegWrite = rw; ImmSrc = is; ALUSrc = as; ALUControl = ac;
    MemtoReg = m2r; MemWrite = mw; PCSrc = pcs; MOVInstr = mov; link = lk;
  endtask

  // One instruction: builds its expected state trace and memory traffic, then
  // steps exactly that many cycles comparing the DUT each cycle.
  task automatic run(input string nm, input logic [31:0] fetch_addr, input bit is_mem,
                     input bit is_store, input int waits, input logic [31:0] maddr,
                     input logic [31:0] wdata, input logic [3:0] flags_e);
    int   seq[$];
    int   w;
    logic rdy;
    txn_t t;
    seq = {0, 1, 2};
    if (is_mem) repeat (waits + 1) seq.push_back(3);
    if (!is_store) seq.push_back(4);
    exp_mem.push_back('{1'b0, fetch_addr, 32'h0});
    if (is_mem) exp_mem.push_back('{is_store, maddr, wdata});
    w = waits;
    for (int i = 0; i < seq.size(); i++) begin
      #1;
      chk({nm, " state"}, 32'(state), 32'(seq[i]));
      chk({nm, " instr_done"}, 32'(instr_done), (i == 0) ? 32'(done_exp) : 32'h0);
      if (i == 3) chk({nm, " flags"}, 32'(ALUFlags), 32'(flags_e));
      if (seq[i] == 0 || seq[i] == 3) begin
        rdy = !(seq[i] == 3 && w > 0);
        if (!rdy) w--;
        t = exp_mem[0];
        chk({nm, " mem_req"}, 32'(mem_req), 32'h1);
        chk({nm, " mem_we"}, 32'(mem_we), 32'(t.we));
        chk({nm, " mem_addr"}, mem_addr, t.addr);
        if (t.we) chk({nm, " mem_wdata"}, mem_wdata, t.wdata);
        if (rdy) void'(exp_mem.pop_front());
      end else begin
        rdy = 1'b1;
        chk({nm, " mem_req idle"}, 32'(mem_req), 32'h0);
      end
      mem_ready = rdy;
      @(negedge CLK);
    end
    done_exp = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h0000_1005;  // ADD R1 = R0 + #5
    mem[1]  = 32'h0001_2001;  // SUB R2 = R1 - R1
    mem[2]  = 32'h0000_1100;  // STR R1, [R0, #0x100]
    mem[3]  = 32'h0000_3100;  // LDR R3, [R0, #0x100]
    mem[4]  = 32'h0000_4104;  // LDR R4, [R0, #0x104]
    mem[5]  = 32'h0004_5001;  // ADD R5 = R4 + #1
    mem[6]  = 32'h0000_5108;  // STR R5, [R0, #0x108]
    mem[7]  = 32'h0003_6084;  // MOV-form ADD R6 = 0 + (R4 LSL 1)
    mem[8]  = 32'h0000_0002;  // BL +2 words
    mem[12] = 32'h0000_E110;  // STR R14, [R0, #0x110]
    mem[13] = 32'h0000_1114;  // STR R1, [R0, #0x114] (interrupted by reset)
    mem[65] = 32'h7FFF_FFFF;
    mem[69] = 32'hDEAD_BEEF;

    reset = 1'b1;
    mem_ready = 1'b1;
    ctl(2'b00, 0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    chk("rst state", 32'(state), 32'h0);
    chk("rst PC", PC, 32'h0);
    chk("rst Instr", Instr, 32'h0);
    chk("rst flags", 32'(ALUFlags), 32'h0);
    chk("rst mem_req", 32'(mem_req), 32'h0);
    chk("rst instr_done", 32'(instr_done), 32'h0);
    chk("rst instr_count", instr_count, 32'h0);
    chk("rst stall_count", stall_count, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b1;

    ctl(2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);
    run("add_imm", 32'h00, 0, 0, 0, 0, 0, 4'b0000);
    ctl(2'b00, 1, 2'b00, 0, 2'b01, 0, 0, 0, 0, 0);
    run("sub_zero", 32'h04, 0, 0, 0, 0, 0, 4'b0110);
    ctl(2'b10, 0, 2'b01, 1, 2'b00, 0, 1, 0, 0, 0);
    run("str_stall", 32'h08, 1, 1, 3, 32'h100, 32'h5, 4'b0000);
    #1;
    chk("str mem", mem[64], 32'h5);
`ifdef MULTICYCLE_DP_PERF_CNT_EN
    chk("stall_count", stall_count, 32'd3);
    chk("instr_count", instr_count, 32'd3);
`else
    chk("stall_count", stall_count, 32'd0);
    chk("instr_count", instr_count, 32'd0);
`endif
    ctl(2'b00, 1, 2'b01, 1, 2'b00, 1, 0, 0, 0, 0);
    run("ldr_r3", 32'h0C, 1, 0, 0, 32'h100, 0, 4'b0000);
    run("ldr_r4", 32'h10, 1, 0, 1, 32'h104, 0, 4'b0000);
    ctl(2'b00, 1, 2'b00, 1, 2'b00, 0, 0, 0, 0, 0);
    run("add_ovf", 32'h14, 0, 0, 0, 0, 0, 4'b1001);
    ctl(2'b10, 0, 2'b01, 1, 2'b00, 0, 1, 0, 0, 0);
    run("str_r5", 32'h18, 1, 1, 0, 32'h108, 32'h8000_0000, 4'b0000);
    ctl(2'b00, 1, 2'b00, 0, 2'b00, 0, 0, 0, 1, 0);
    run("mov_lsl", 32'h1C, 0, 0, 0, 0, 0, 4'b1000);
    ctl(2'b01, 0, 2'b10, 1, 2'b00, 0, 0, 1, 0, 1);
    run("bl", 32'h20, 0, 0, 0, 0, 0, 4'b0000);
    ctl(2'b10, 0, 2'b01, 1, 2'b00, 0, 1, 0, 0, 0);
    run("str_r14", 32'h30, 1, 1, 0, 32'h110, 32'h24, 4'b0000);
    #1;
    chk("ovf mem", mem[66], 32'h8000_0000);
    chk("link mem", mem[68], 32'h24);

    // Store abandoned by reset while stalled in MEMORY
    ctl(2'b10, 0, 2'b01, 1, 2'b00, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rst_str walk", 32'(state), 32'(i));
      mem_ready = 1'b1;
      @(negedge CLK);
      #1;
    end
    chk("rst_str state", 32'(state), 32'h3);
    chk("rst_str mem_req", 32'(mem_req), 32'h1);
    chk("rst_str mem_addr", mem_addr, 32'h114);
    mem_ready = 1'b0;
    @(negedge CLK);
    #1 reset = 1'b0;
    #1;
    chk("rst_str req drop", 32'(mem_req), 32'h0);
    chk("rst_str state0", 32'(state), 32'h0);
    chk("rst_str PC", PC, 32'h0);
    chk("rst_str instr_count", instr_count, 32'h0);
    mem_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_str mem kept", mem[69], 32'hDEAD_BEEF);
    reset = 1'b1;
    #1;
    chk("rst_str refetch req", 32'(mem_req), 32'h1);
    chk("rst_str refetch addr", mem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
